// File: rtl/fifo_read_packer.sv
// Read-side FIFO consumer: pops DSIZE-bit words and packs PACK of them into one valid/ready beat.
// Optional partial-beat flush (flush/m_cnt ports) is compiled in when RD_PACK_FLUSH_EN is defined.
module fifo_read_packer #(
   parameter  int DSIZE = 6,
   parameter  int PACK  = 4,
   localparam int CW    = $clog2(PACK + 1)
) (
   input  logic                  rclk,
   input  logic                  rrst,
   input  logic                  rempty,
   output logic                  rinc,
   input  logic [DSIZE-1:0]      rdata,
   output logic [DSIZE*PACK-1:0] m_data,
   output logic                  m_valid,
   input  logic                  m_ready
`ifdef RD_PACK_FLUSH_EN
   ,
   input  logic                  flush,
   output logic [CW-1:0]         m_cnt
`endif
);

   localparam logic [CW-1:0] FULL_CNT = CW'(PACK);
   localparam logic [CW:0]   PACK_W   = (CW + 1)'(PACK);

   logic [DSIZE-1:0]      r_pack_buf [PACK];
   logic [CW-1:0]         r_fill_cnt;
   logic                  r_pend;
   logic [DSIZE*PACK-1:0] r_m_data;
   logic                  r_m_valid;

   logic [DSIZE*PACK-1:0] w_beat;
   logic [CW:0]           w_inflight;
   logic                  w_out_free;
   logic                  w_full;
   logic                  w_xfer;
   logic                  w_flush_go;
   logic                  w_rinc_block;

   assign w_out_free = !r_m_valid || m_ready;
   assign w_full     = (r_fill_cnt == FULL_CNT);
   // Words already captured plus the one in flight; capping this at PACK keeps fill_cnt from wrapping.
   assign w_inflight = {1'b0, r_fill_cnt} + {{CW{1'b0}}, r_pend};

   // Lanes at or above fill_cnt read as zero so a partial beat never carries stale words.
   genvar gi;
   generate
      for (gi = 0; gi < PACK; gi++) begin : g_lane
         assign w_beat[gi*DSIZE +: DSIZE] = (CW'(gi) < r_fill_cnt) ? r_pack_buf[gi] : '0;
      end
   endgenerate

`ifdef RD_PACK_FLUSH_EN
   logic          r_flush_req;
   logic [CW-1:0] r_m_cnt;
   logic          w_flush_done;

   assign w_flush_go   = r_flush_req && !r_pend && (r_fill_cnt != '0) && !w_full;
   assign w_flush_done = r_flush_req && !r_pend &&
                         ((r_fill_cnt == '0) || (w_flush_go && w_out_free));
   assign w_rinc_block = r_flush_req;

   always_ff @(posedge rclk) begin
      if (rrst) begin
         r_flush_req <= 1'b0;
         r_m_cnt     <= '0;
      end else begin
         r_flush_req <= (r_flush_req && !w_flush_done) || flush;
         if (w_xfer) begin
            r_m_cnt <= r_fill_cnt;
         end
      end
   end

   assign m_cnt = r_m_cnt;
`else
   assign w_flush_go   = 1'b0;
   assign w_rinc_block = 1'b0;
`endif

   assign w_xfer = w_out_free && (w_full || w_flush_go);
   assign rinc   = !rrst && !rempty && !w_rinc_block && (w_inflight < PACK_W);

   always_ff @(posedge rclk) begin
      if (rrst) begin
         r_pend     <= 1'b0;
         r_fill_cnt <= '0;
         r_m_data   <= '0;
         r_m_valid  <= 1'b0;
         for (int i = 0; i < PACK; i++) begin
            r_pack_buf[i] <= '0;
         end
      end else begin
         r_pend <= rinc;
         if (r_pend) begin
            for (int i = 0; i < PACK; i++) begin
               if (r_fill_cnt == CW'(i)) begin
                  r_pack_buf[i] <= rdata;
               end
            end
            r_fill_cnt <= r_fill_cnt + CW'(1);
         end
         // A transfer never coincides with a capture: both full and flush transfers need pend=0.
         if (w_xfer) begin
            r_m_data   <= w_beat;
            r_m_valid  <= 1'b1;
            r_fill_cnt <= '0;
         end else if (r_m_valid && m_ready) begin
            r_m_valid <= 1'b0;
         end
      end
   end

   assign m_data  = r_m_data;
   assign m_valid = r_m_valid;

endmodule

// File: tb/tb_fifo_read_packer.sv
// Directed bench for fifo_read_packer (DSIZE=6, PACK=4) with a queue-based FIFO read-port model.
`timescale 1ns/1ps
module tb_fifo_read_packer;

   logic        rclk = 1'b0;
   logic        rrst = 1'b1;
   logic        rempty = 1'b1;
   logic        rinc;
   logic [5:0]  rdata = '0;
   logic [23:0] m_data;
   logic        m_valid;
   logic        m_ready = 1'b0;
`ifdef RD_PACK_FLUSH_EN
   logic        flush = 1'b0;
   logic [2:0]  m_cnt;
`endif

   int          total = 0;
   int          bad = 0;
   int          pops = 0;
   logic        last_rinc = 1'b0;
   logic        tog = 1'b0;
   logic        toggle_en = 1'b0;
   logic [5:0]  fifo_q [$];
   logic [23:0] beat_q [$];
   logic [2:0]  cnt_q [$];

   fifo_read_packer #(.DSIZE(6), .PACK(4)) dut (
      .rclk    (rclk),
      .rrst    (rrst),
      .rempty  (rempty),
      .rinc    (rinc),
      .rdata   (rdata),
      .m_data  (m_data),
      .m_valid (m_valid),
      .m_ready (m_ready)
`ifdef RD_PACK_FLUSH_EN
      ,
      .flush   (flush),
      .m_cnt   (m_cnt)
`endif
   );

   always #5 rclk = ~rclk;

   task automatic update_empty();
      rempty = (fifo_q.size() == 0) || (toggle_en && tog);
   endtask

   // One clock: sample at negedge, then model the FIFO read port just after the posedge.
   task automatic tick();
      @(negedge rclk);
      last_rinc = rinc;
      total++;
      if (rinc && rempty) begin
         bad++;
         $display("FAIL rinc_while_empty: rinc=%0b rempty=%0b required rinc=0", rinc, rempty);
      end
      if (m_valid && m_ready) begin
         beat_q.push_back(m_data);
`ifdef RD_PACK_FLUSH_EN
         cnt_q.push_back(m_cnt);
         $display("beat accepted: data=%06h cnt=%0d", m_data, m_cnt);
`else
         $display("beat accepted: data=%06h", m_data);
`endif
      end
      @(posedge rclk);
      #1;
      if (last_rinc) begin
         if (fifo_q.size() > 0) rdata = fifo_q.pop_front();
         pops++;
      end
      tog = !tog;
      update_empty();
   endtask

   task automatic load_words(input int first, input int count);
      for (int i = 0; i < count; i++) fifo_q.push_back(6'(first + i));
      update_empty();
   endtask

   task automatic do_reset();
      fifo_q.delete();
      update_empty();
      rrst = 1'b1;
      tick();
      tick();
      rrst = 1'b0;
      beat_q.delete();
      cnt_q.delete();
      pops = 0;
   endtask

   task automatic test_reset();
      rrst = 1'b1;
      load_words(1, 4);
      for (int c = 0; c < 3; c++) begin
         tick();
         total++;
         if (last_rinc !== 1'b0) begin
            bad++; $display("FAIL reset_rinc: got=%0b want=0", last_rinc);
         end
         total++;
         if (m_valid !== 1'b0) begin
            bad++; $display("FAIL reset_m_valid: got=%0b want=0", m_valid);
         end
         total++;
         if (m_data !== 24'h0) begin
            bad++; $display("FAIL reset_m_data: got=%06h want=000000", m_data);
         end
      end
      total++;
      if (pops !== 0) begin
         bad++; $display("FAIL reset_pops: got=%0d want=0", pops);
      end
      do_reset();
   endtask

   task automatic test_two_beats();
      do_reset();
      m_ready = 1'b1;
      load_words(1, 8);
      for (int c = 0; c < 24; c++) tick();
      total++;
      if (beat_q.size() !== 2) begin
         bad++; $display("FAIL two_beats_count: got=%0d want=2", beat_q.size());
      end else begin
         total++;
         if (beat_q[0] !== 24'h103081) begin
            bad++; $display("FAIL two_beats_b0: got=%06h want=103081", beat_q[0]);
         end
         total++;
         if (beat_q[1] !== 24'h207185) begin
            bad++; $display("FAIL two_beats_b1: got=%06h want=207185", beat_q[1]);
         end
`ifdef RD_PACK_FLUSH_EN
         total++;
         if (cnt_q[0] !== 3'd4) begin
            bad++; $display("FAIL two_beats_cnt: got=%0d want=4", cnt_q[0]);
         end
`endif
      end
      total++;
      if (pops !== 8) begin
         bad++; $display("FAIL two_beats_pops: got=%0d want=8", pops);
      end
      total++;
      if (m_valid !== 1'b0) begin
         bad++; $display("FAIL two_beats_idle_valid: got=%0b want=0", m_valid);
      end
   endtask

   task automatic test_backpressure();
      int waited;
      do_reset();
      m_ready = 1'b0;
      load_words(1, 12);
      waited = 0;
      while (m_valid !== 1'b1 && waited < 30) begin
         tick();
         waited++;
      end
      total++;
      if (m_valid !== 1'b1) begin
         bad++; $display("FAIL bp_first_valid: got=%0b want=1 within 30 cycles", m_valid);
      end
      for (int c = 0; c < 20; c++) begin
         tick();
         total++;
         if (m_valid !== 1'b1 || m_data !== 24'h103081) begin
            bad++;
            $display("FAIL bp_hold: valid=%0b data=%06h want valid=1 data=103081", m_valid, m_data);
         end
      end
      total++;
      if (last_rinc !== 1'b0) begin
         bad++; $display("FAIL bp_rinc_stalled: got=%0b want=0", last_rinc);
      end
      total++;
      if (pops !== 8) begin
         bad++; $display("FAIL bp_pops_held: got=%0d want=8", pops);
      end
      m_ready = 1'b1;
      for (int c = 0; c < 24; c++) tick();
      total++;
      if (beat_q.size() !== 3) begin
         bad++; $display("FAIL bp_beat_count: got=%0d want=3", beat_q.size());
      end else begin
         total++;
         if (beat_q[0] !== 24'h103081 || beat_q[1] !== 24'h207185 || beat_q[2] !== 24'h30b289) begin
            bad++;
            $display("FAIL bp_beats: got=%06h,%06h,%06h want=103081,207185,30b289",
                     beat_q[0], beat_q[1], beat_q[2]);
         end
      end
      total++;
      if (pops !== 12) begin
         bad++; $display("FAIL bp_pops_total: got=%0d want=12", pops);
      end
   endtask

   task automatic test_toggle_empty();
      do_reset();
      m_ready = 1'b1;
      toggle_en = 1'b1;
      load_words(1, 4);
      for (int c = 0; c < 30; c++) tick();
      toggle_en = 1'b0;
      update_empty();
      total++;
      if (beat_q.size() !== 1) begin
         bad++; $display("FAIL toggle_beat_count: got=%0d want=1", beat_q.size());
      end else begin
         total++;
         if (beat_q[0] !== 24'h103081) begin
            bad++; $display("FAIL toggle_beat: got=%06h want=103081", beat_q[0]);
         end
      end
      total++;
      if (pops !== 4) begin
         bad++; $display("FAIL toggle_pops: got=%0d want=4", pops);
      end
   endtask

   task automatic test_mid_reset();
      int waited;
      do_reset();
      m_ready = 1'b1;
      load_words(1, 3);
      waited = 0;
      while (pops < 3 && waited < 20) begin
         tick();
         waited++;
      end
      total++;
      if (pops !== 3) begin
         bad++; $display("FAIL midrst_pops: got=%0d want=3 within 20 cycles", pops);
      end
      rrst = 1'b1;
      tick();
      tick();
      rrst = 1'b0;
      total++;
      if (m_valid !== 1'b0 || m_data !== 24'h0) begin
         bad++; $display("FAIL midrst_cleared: valid=%0b data=%06h want 0/000000", m_valid, m_data);
      end
      load_words(5, 4);
      for (int c = 0; c < 20; c++) tick();
      total++;
      if (beat_q.size() !== 1) begin
         bad++; $display("FAIL midrst_beat_count: got=%0d want=1", beat_q.size());
      end else begin
         total++;
         if (beat_q[0] !== 24'h207185) begin
            bad++; $display("FAIL midrst_beat: got=%06h want=207185", beat_q[0]);
         end
      end
   endtask

`ifdef RD_PACK_FLUSH_EN
   task automatic test_flush();
      int waited;
      do_reset();
      m_ready = 1'b0;
      fifo_q.push_back(6'h11);
      fifo_q.push_back(6'h22);
      update_empty();
      for (int c = 0; c < 8; c++) tick();
      total++;
      if (m_valid !== 1'b0) begin
         bad++; $display("FAIL flush_no_early_beat: got=%0b want=0", m_valid);
      end
      flush = 1'b1;
      tick();
      flush = 1'b0;
      waited = 0;
      while (m_valid !== 1'b1 && waited < 20) begin
         tick();
         waited++;
      end
      total++;
      if (m_valid !== 1'b1) begin
         bad++; $display("FAIL flush_valid: got=%0b want=1 within 20 cycles", m_valid);
      end
      total++;
      if (m_data !== 24'h000891) begin
         bad++; $display("FAIL flush_data: got=%06h want=000891", m_data);
      end
      total++;
      if (m_cnt !== 3'd2) begin
         bad++; $display("FAIL flush_cnt: got=%0d want=2", m_cnt);
      end
      for (int c = 0; c < 3; c++) begin
         tick();
         total++;
         if (last_rinc !== 1'b0 || m_valid !== 1'b1) begin
            bad++; $display("FAIL flush_hold: rinc=%0b valid=%0b want rinc=0 valid=1", last_rinc, m_valid);
         end
      end
      m_ready = 1'b1;
      tick();
      tick();
      total++;
      if (beat_q.size() !== 1) begin
         bad++; $display("FAIL flush_beat_count: got=%0d want=1", beat_q.size());
      end else begin
         total++;
         if (beat_q[0] !== 24'h000891 || cnt_q[0] !== 3'd2) begin
            bad++; $display("FAIL flush_beat: got=%06h/%0d want=000891/2", beat_q[0], cnt_q[0]);
         end
      end
   endtask
`endif

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      test_reset();
      test_two_beats();
      test_backpressure();
      test_toggle_empty();
      test_mid_reset();
`ifdef RD_PACK_FLUSH_EN
      test_flush();
`endif
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
